// File: rtl/mux_rr_nto1.sv
// mux_rr_nto1: N-to-1 arbitrating multiplexer with round-robin selection,
// bounded burst hold, a combinational pop back to the sources and a
// registered output stream. Define MUX_FIXED_PRIO_EN to replace the
// round-robin search with fixed lowest-index-first priority.
module mux_rr_nto1 #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]            valid_in,
  input  logic                           pause_in,
  output logic [CHANNELS-1:0]            pop_out,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic                           valid_out,
  output logic [$clog2(CHANNELS)-1:0]    sel_out
);

  localparam int unsigned SEL_W = $clog2(CHANNELS);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [SEL_W-1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic [SEL_W-1:0]        sel_q, sel_d;

  logic [DATA_WIDTH-1:0]   ch_data [CHANNELS];
  logic                    found;
  logic [SEL_W-1:0]        win;
  logic [SEL_W-1:0]        cand;
  logic                    hold;

  // Unpack the flat input bus into per-channel words.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
    assign ch_data[gi] = data_in[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // The current owner (ptr_q) keeps the grant while it is valid and has burst budget left.
  assign hold = (state_q == GRANT) && valid_in[ptr_q] && (cnt_q < CNT_W'(MAX_BURST));

  // Search for the first valid channel; the round-robin order visits the former owner last.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    cand  = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
`ifdef MUX_FIXED_PRIO_EN
      cand = SEL_W'(k);
`else
      cand = SEL_W'((32'(ptr_q) + 32'd1 + k) % CHANNELS);
`endif
      if (!found && valid_in[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Next-state, pop and next-output logic; pause freezes everything except valid.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    sel_d   = sel_q;
    valid_d = 1'b0;
    pop_out = '0;
    if (!pause_in) begin
      if (hold) begin
        pop_out[ptr_q] = 1'b1;
        data_d         = ch_data[ptr_q];
        sel_d          = ptr_q;
        valid_d        = 1'b1;
        cnt_d          = cnt_q + CNT_W'(1);
        state_d        = GRANT;
      end else if (found) begin
        pop_out[win] = 1'b1;
        data_d       = ch_data[win];
        sel_d        = win;
        valid_d      = 1'b1;
        ptr_d        = win;
        cnt_d        = CNT_W'(1);
        state_d      = GRANT;
      end else begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    end
    if (reset) begin
      pop_out = '0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= SEL_W'(CHANNELS - 1);
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign sel_out   = sel_q;

endmodule

// File: doc/mux_rr_nto1.md
# mux_rr_nto1

Parametrised N-to-1 arbitrating multiplexer. It merges CHANNELS valid-qualified data streams from upstream FIFOs into one registered output stream. Selection is round-robin with bounded burst hold, and a pop handshake goes back to the sources. Downstream backpressure is honoured through a pause input. It is the successor to the fixed 2-to-1 lane muxes and sits between the per-lane FIFOs and the output stage.

## Interface
- CHANNELS, 4, number of input channels; must be ≥2.
- DATA_WIDTH, 8, bits per channel word.
- MAX_BURST, 2, maximum consecutive transfers granted to one channel before re-arbitration; must be ≥1.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- data_in  in  CHANNELS*DATA_WIDTH  packed inputs; channel i at [i*DATA_WIDTH +: DATA_WIDTH].
- valid_in  in  CHANNELS  bit i high: channel i has a word available.
- pause_in  in  1  downstream almost-full; no transfer while high.
- pop_out  out  CHANNELS  one-hot, combinational; pops the granted source FIFO in the transfer cycle.
- data_out  out  DATA_WIDTH  registered selected word.
- valid_out  out  1  registered; data_out is valid.
- sel_out  out  $clog2(CHANNELS)  registered index of the channel that produced data_out.

## Operation
- State machine, two states:
  - IDLE: no owner.
  - GRANT: owner held, with burst counter burst_cnt of width $clog2(MAX_BURST+1).
- Arbitration each cycle when pause_in=0:
  - In GRANT with valid_in[owner]=1 and burst_cnt<MAX_BURST, keep the owner.
  - Otherwise search from ptr+1 upward, wrapping modulo CHANNELS, for the first valid_in bit. The former owner is therefore considered last.
- Transfer cycle (winner g exists and pause_in=0):
  - pop_out[g]=1.
  - Next edge: data_out←data_in[g], valid_out←1, sel_out←g, ptr←g.
  - State←GRANT. burst_cnt←burst_cnt+1 if g equals the current owner, otherwise burst_cnt←1.
- No winner (all valid_in=0):
  - pop_out=0; next edge valid_out←0.
  - data_out and sel_out hold their values. State←IDLE, burst_cnt←0.
- pause_in=1:
  - pop_out=0; next edge valid_out←0.
  - data_out, sel_out, state, owner, ptr and burst_cnt all hold, so the burst resumes after the pause.
- Owner drops valid_in while in GRANT: re-arbitrate in the same cycle with no bubble if another channel is valid.
- Burst expiry with no competing requester: the same channel is re-granted and burst_cnt restarts at 1.
- pop_out is never asserted while reset=1.

## Timing
- Reset (synchronous, sampled at the edge):
  - data_out=0, valid_out=0, sel_out=0, pop_out=0.
  - ptr=CHANNELS-1, so channel 0 is searched first. State=IDLE, burst_cnt=0.
- Latency: one cycle from pop_out[g] to valid_out=1 carrying the word from channel g.
- Throughput: one word per cycle while any channel is valid and pause_in=0.
- pop_out depends combinationally on valid_in, pause_in, reset and registered state. It has no path from data_in.
- Reset mid-burst:
  - The grant is abandoned and no pop occurs in the reset cycle.
  - The first post-reset grant goes to the lowest-index valid channel.

## Configuration
- MUX_FIXED_PRIO_EN defined:
  - The search always starts at channel 0; the lowest-index valid channel wins.
  - Burst hold still applies. On expiry, the lowest-index valid channel wins again, so starvation of higher indices is accepted.
  - ptr is still maintained but unused by arbitration.
- MUX_FIXED_PRIO_EN undefined: round-robin as described above (default).

## Test plan
All scenarios use CHANNELS=4, DATA_WIDTH=8, MAX_BURST=2.
- Reset held 2 cycles with all inputs active -> data_out=0x00, valid_out=0, sel_out=0, pop_out=4'b0000 throughout reset.
- All valid_in=4'b1111, data 0xA0..0xA3 constant, pause_in=0 -> sel_out sequence 0,0,1,1,2,2,3,3,0,0 on consecutive cycles; valid_out stays 1; data_out tracks 0xA0/0xA1/0xA2/0xA3 accordingly.
- Only valid_in[2]=1 with data 0x5C for 5 cycles -> pop_out=4'b0100 in each of the 5 cycles; data_out=0x5C and sel_out=2 for 5 cycles starting 1 cycle later; then valid_out=0 and data_out holds 0x5C.
- All valid, pause_in=1 for 3 cycles after the first ch0 transfer -> pop_out=0 and valid_out=0 during the pause; after release, ch0 transfers once more (completing its burst of 2), then ch1.
- Reset pulsed mid-burst on ch3 with valid_in=4'b1010 -> valid_out=0 the cycle after reset; the first grant after reset is ch1.
- Build with MUX_FIXED_PRIO_EN, valid_in=4'b1010 for 6 cycles -> sel_out=1 on every cycle and ch3 is never popped; without the macro, sel_out alternates 1,1,3,3,1,1.
